rf_wb_queue: RTL and testbench

//  Write-back queue directly upstream of the 8x16 register file. Accepts results

---
 rtl/rf_wb_pkg.sv | 18 +
 rtl/wb_fifo2w.sv | 47 ++++
 rtl/rf_wb_queue.sv | 103 ++++++++++
 tb/tb_rf_wb_queue.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types and sizing helpers for the register-file write-back queue.
package rf_wb_pkg;

  localparam int AW   = 3;
  localparam int DW   = 16;
  localparam int REGS = 2 ** AW;

  typedef struct packed {
    logic [AW-1:0] sel;
    logic [DW-1:0] data;
  } wb_entry_t;

  // Holds up to DEPTH queued writes plus the one sitting in the output stage.
  function automatic int pend_cnt_w(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/wb_fifo2w.sv
// Ordered dual-push, single-pop FIFO of write-back entries; port 0 lands ahead of port 1.
module wb_fifo2w
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push0,
  input  wb_entry_t                data0,
  input  logic                     push1,
  input  wb_entry_t                data1,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [PW-1:0] wa0;
  logic [PW-1:0] wa1;
  wb_entry_t     store [DEPTH];

  assign wa0   = wr_ptr[PW-1:0];
  assign wa1   = wa0 + 1'b1;
  assign count = wr_ptr - rd_ptr;
  assign head  = store[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (PW+1)'(push0) + (PW+1)'(push1);
      rd_ptr <= rd_ptr + (PW+1)'(pop && (count != '0));
    end
  end

  // A lone port-1 push takes the first free slot so entries stay contiguous.
  always_ff @(posedge clk) begin
    if (push0 || push1) store[wa0] <= push0 ? data0 : data1;
    if (push0 && push1) store[wa1] <= data1;
  end

endmodule

// File: rtl/rf_wb_queue.sv
// Write-back queue feeding the register file's single write port, with per-register hazard mask.
module rf_wb_queue
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = rf_wb_pkg::DW,
  parameter int AW    = rf_wb_pkg::AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [AW-1:0]     mem_regsel,
  input  logic [DW-1:0]     mem_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [AW-1:0]     alu_regsel,
  input  logic [DW-1:0]     alu_data,
  output logic              write,
  output logic [AW-1:0]     writeregsel,
  output logic [DW-1:0]     writedata,
  output logic [2**AW-1:0]  busy,
  output logic              idle
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = pend_cnt_w(DEPTH);
  localparam int NREG = 2 ** AW;

  logic [PW:0]   count;
  logic [PW:0]   free;
  logic          mem_acc;
  logic          alu_acc;
  logic          pop;
  wb_entry_t     head;
  wb_entry_t     mem_e;
  wb_entry_t     alu_e;
  logic [CW-1:0] cnt     [NREG];
  logic [CW-1:0] cnt_nxt [NREG];

  assign mem_e = '{sel: mem_regsel, data: mem_data};
  assign alu_e = '{sel: alu_regsel, data: alu_data};

  // Free space ignores a same-cycle pop, so acceptance never relies on the drain.
  assign free      = (PW+1)'(DEPTH) - count;
  assign mem_ready = rst & (free != '0);
  assign alu_ready = rst & ((free >= (PW+1)'(2)) | ((free == (PW+1)'(1)) & ~mem_valid));
  assign mem_acc   = mem_valid & mem_ready;
  assign alu_acc   = alu_valid & alu_ready;
  assign pop       = (count != '0);
  assign idle      = (count == '0) & ~write;

  wb_fifo2w #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push0 (mem_acc),
    .data0 (mem_e),
    .push1 (alu_acc),
    .data1 (alu_e),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  // Output stage: one registered rf write per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write       <= 1'b0;
      writeregsel <= '0;
      writedata   <= '0;
    end else begin
      write <= pop;
      if (pop) begin
        writeregsel <= head.sel;
        writedata   <= head.data;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt[r] = cnt[r];
      if (mem_acc && (mem_regsel == AW'(r))) cnt_nxt[r] = cnt_nxt[r] + CW'(1);
      if (alu_acc && (alu_regsel == AW'(r))) cnt_nxt[r] = cnt_nxt[r] + CW'(1);
      if (write && (writeregsel == AW'(r)))  cnt_nxt[r] = cnt_nxt[r] - CW'(1);
    end
  end

  // Pending counters: a register stays busy until its last queued write retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NREG; r++) busy[r] = (cnt[r] != '0);
  end

endmodule

// File: tb/tb_rf_wb_queue.sv
// Directed bench for rf_wb_queue: ready rules, ordering, hazard mask, reset and throughput.
module tb_rf_wb_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_valid, alu_valid;
  logic          mem_ready, alu_ready;
  logic [AW-1:0] mem_regsel, alu_regsel;
  logic [DW-1:0] mem_data, alu_data;
  logic          write;
  logic [AW-1:0] writeregsel;
  logic [DW-1:0] writedata;
  logic [7:0]    busy;
  logic          idle;

  int total = 0;
  int bad   = 0;

  logic [18:0] exp_q[$];
  int          mcount;
  int          wr_seen;
  logic [15:0] rf_tb [8];

  always #5 clk = ~clk;

  rf_wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_regsel  (mem_regsel),
    .mem_data    (mem_data),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_regsel  (alu_regsel),
    .alu_data    (alu_data),
    .write       (write),
    .writeregsel (writeregsel),
    .writedata   (writedata),
    .busy        (busy),
    .idle        (idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Every rf write must match the next entry the bench expects, in order.
  always @(negedge clk) begin
    if (rst === 1'b1 && write === 1'b1) begin
      wr_seen++;
      rf_tb[writeregsel] = writedata;
      chk("wr_expected", 32'(write), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("wr_order", {13'b0, writeregsel, writedata}, {13'b0, exp_q[0]});
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic mv, input logic [2:0] ms, input logic [15:0] md,
                      input logic av, input logic [2:0] asel, input logic [15:0] ad,
                      output logic am, output logic aa);
    int   fr;
    logic em, ea;
    mem_valid = mv; mem_regsel = ms; mem_data = md;
    alu_valid = av; alu_regsel = asel; alu_data = ad;
    #1;
    fr = DEPTH - mcount;
    em = (fr >= 1);
    ea = (fr >= 2) || (fr == 1 && !mv);
    chk("mem_ready", 32'(mem_ready), 32'(em));
    chk("alu_ready", 32'(alu_ready), 32'(ea));
    am = mv && em;
    aa = av && ea;
    if (am) exp_q.push_back({ms, md});
    if (aa) exp_q.push_back({asel, ad});
    @(posedge clk);
    mcount = mcount + int'(am) + int'(aa) - ((mcount > 0) ? 1 : 0);
    #1;
    mem_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic idle_cyc(input int n);
    logic a, b;
    repeat (n) step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, a, b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        am, aa;
    logic [18:0] items [64];
    int          idx, k, guard;

    rst = 1'b0; mcount = 0; wr_seen = 0;
    mem_valid = 1'b1; alu_valid = 1'b0;
    mem_regsel = '0; alu_regsel = '0; mem_data = '0; alu_data = '0;
    for (int i = 0; i < 8; i++) rf_tb[i] = '0;
    #12;
    chk("rst_write", 32'(write), 0);
    chk("rst_sel", 32'(writeregsel), 0);
    chk("rst_data", 32'(writedata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_mem_ready", 32'(mem_ready), 0);
    chk("rst_alu_ready", 32'(alu_ready), 0);
    mem_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // single mem push
    step(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0, am, aa);
    chk("t1_write_n", 32'(write), 0);
    chk("t1_busy_n", 32'(busy[3]), 1);
    chk("t1_idle_n", 32'(idle), 0);
    idle_cyc(1);
    chk("t1_write_n1", 32'(write), 1);
    chk("t1_sel", 32'(writeregsel), 3);
    chk("t1_data", 32'(writedata), 32'hBEEF);
    chk("t1_busy_n1", 32'(busy[3]), 1);
    idle_cyc(1);
    chk("t1_write_n2", 32'(write), 0);
    chk("t1_busy_n2", 32'(busy[3]), 0);
    chk("t1_idle_n2", 32'(idle), 1);

    // same-cycle pushes to one register
    step(1'b1, 3'd1, 16'h1111, 1'b1, 3'd1, 16'h2222, am, aa);
    chk("t2_cnt_peak", 32'(dut.cnt[1]), 2);
    chk("t2_busy_a", 32'(busy[1]), 1);
    idle_cyc(1);
    chk("t2_first", {16'h0, writedata}, 32'h1111);
    chk("t2_cnt_a", 32'(dut.cnt[1]), 2);
    idle_cyc(1);
    chk("t2_second", {16'h0, writedata}, 32'h2222);
    chk("t2_busy_b", 32'(busy[1]), 1);
    chk("t2_cnt_b", 32'(dut.cnt[1]), 1);
    idle_cyc(1);
    chk("t2_busy_c", 32'(busy[1]), 0);
    chk("t2_cnt_c", 32'(dut.cnt[1]), 0);

    // two offers per cycle, 64 random items
    wr_seen = 0;
    for (int i = 0; i < 64; i++) items[i] = {3'($urandom), 16'($urandom)};
    idx = 0; guard = 0;
    while (idx < 64 && guard < 300) begin
      k = (idx + 1 < 64) ? idx + 1 : idx;
      step(1'b1, items[idx][18:16], items[idx][15:0],
           (idx + 1 < 64), items[k][18:16], items[k][15:0], am, aa);
      idx = idx + int'(am) + int'(aa);
      guard++;
    end
    chk("t3_all_offered", 32'(idx), 64);
    idle_cyc(6);
    chk("t3_writes", 32'(wr_seen), 64);
    chk("t3_left", 32'(exp_q.size()), 0);
    chk("t3_idle", 32'(idle), 1);

    // free==1 arbitration, then count=3 with write=1
    step(1'b1, 3'd2, 16'hA002, 1'b1, 3'd3, 16'hA003, am, aa);
    step(1'b1, 3'd4, 16'hA004, 1'b1, 3'd5, 16'hA005, am, aa);
    step(1'b1, 3'd6, 16'hA006, 1'b1, 3'd0, 16'hA000, am, aa);
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 16'hA000, am, aa);
    chk("t4_write_active", 32'(write), 1);
    chk("t4_busy_set", 32'(busy != 0), 1);

    // asynchronous reset mid-operation
    #2;
    rst = 1'b0;
    #1;
    chk("t5_write", 32'(write), 0);
    chk("t5_data", 32'(writedata), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_idle", 32'(idle), 1);
    chk("t5_mem_ready", 32'(mem_ready), 0);
    chk("t5_alu_ready", 32'(alu_ready), 0);
    exp_q.delete();
    mcount = 0;
    wr_seen = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    idle_cyc(4);
    chk("t5_no_write", 32'(wr_seen), 0);
    chk("t5_idle_after", 32'(idle), 1);

    // sustained alu stream to r7
    wr_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 16'h7000 + 16'(i), am, aa);
      chk("t6_busy", 32'(busy[7]), 1);
      if (i >= 1) chk("t6_write", 32'(write), 1);
    end
    idle_cyc(1);
    chk("t6_busy_tail", 32'(busy[7]), 1);
    idle_cyc(2);
    chk("t6_writes", 32'(wr_seen), 20);
    chk("t6_rf_last", {16'h0, rf_tb[7]}, 32'h7013);
    chk("t6_busy_clear", 32'(busy[7]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
